alu_seq: RTL

Parametrised, registered successor to the team's 8-bit combinational ALU for the Basys3 datapath. It accepts one operation per valid/ready handshake and returns the result with carry, zero, negative and overflow flags through a held output register. It adds carry-chained add, barrel shifts and an optional iterative multiplier. It sits between the switch/operand capture logic and the seven-segment/LED display path.

---
 rtl/alu_seq.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// alu_seq - registered, handshaked ALU for the Basys3 datapath.
//
// Takes one operation per in_valid/in_ready handshake. The result and its
// flags come back through a held output register with an
// out_valid/out_ready handshake. Single-cycle ops load the output register
// on the accept edge. The optional multiplier iterates one partial product
// per cycle.
//
// Build option: define ALU_MUL_EN to compile in opcode 1001 (MUL) and the
// MUL/DONE states. Without it, 1001 is treated as an undefined opcode and
// busy is tied low.
//
// Parameters:
//   WIDTH  operand/result width (4..32)
//   SHW    shift-amount field width, b[SHW-1:0]
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid, in_ready   operation request handshake
//   a, b, alu_sel        operands and opcode, captured on accept
//   out_valid, out_ready result handshake; outputs held while stalled
//   result               registered result
//   carry                carry / borrow / last bit shifted out
//   zero, negative       result == 0, result MSB
//   overflow             signed overflow (ADD/ADC/SUB only)
//   busy                 multiplier in progress
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             negative,
  output logic             overflow,
  output logic             busy
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_NOT = 4'b0101;
  localparam logic [3:0] OP_SHL = 4'b0110;
  localparam logic [3:0] OP_SHR = 4'b0111;
  localparam logic [3:0] OP_ADC = 4'b1000;

  function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

  function automatic logic sub_ovf(input logic sa, input logic sb, input logic sr);
    return (sa != sb) && (sr != sa);
  endfunction

  logic             carry_q;
  logic             accept;
  logic             cin_p0;
  logic [SHW-1:0]   shamt_p0;
  logic [WIDTH:0]   sum_p0;
  logic [WIDTH:0]   diff_p0;
  logic [WIDTH:0]   shl_p0;
  logic [WIDTH:0]   shr_p0;
  logic [WIDTH-1:0] res_p0;
  logic             cy_p0;
  logic             ov_p0;

  logic             load;
  logic [WIDTH-1:0] ld_res;
  logic             ld_cy;
  logic             ld_ov;

  assign accept = in_valid && in_ready;

  // ---- stage p0: single-cycle datapath on the live inputs ----
  // ADD and ADC share one adder; the carry-in is only used for ADC.
  assign cin_p0   = (alu_sel == OP_ADC) ? carry_q : 1'b0;
  assign shamt_p0 = b[SHW-1:0];
  assign sum_p0   = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin_p0);
  // Top bit of the widened difference is the unsigned borrow.
  assign diff_p0  = {1'b0, a} - {1'b0, b};
  // One guard bit on each side catches the last bit shifted out; a zero
  // shift leaves the guard bit clear, so carry is 0 without a special case.
  assign shl_p0   = {1'b0, a} << shamt_p0;
  assign shr_p0   = {a, 1'b0} >> shamt_p0;

  always_comb begin
    res_p0 = '0;
    cy_p0  = 1'b0;
    ov_p0  = 1'b0;
    case (alu_sel)
      OP_ADD, OP_ADC: begin
        res_p0 = sum_p0[WIDTH-1:0];
        cy_p0  = sum_p0[WIDTH];
        ov_p0  = add_ovf(a[WIDTH-1], b[WIDTH-1], sum_p0[WIDTH-1]);
      end
      OP_SUB: begin
        res_p0 = diff_p0[WIDTH-1:0];
        cy_p0  = diff_p0[WIDTH];
        ov_p0  = sub_ovf(a[WIDTH-1], b[WIDTH-1], diff_p0[WIDTH-1]);
      end
      OP_AND: res_p0 = a & b;
      OP_OR:  res_p0 = a | b;
      OP_XOR: res_p0 = a ^ b;
      OP_NOT: res_p0 = ~a;
      OP_SHL: begin
        res_p0 = shl_p0[WIDTH-1:0];
        cy_p0  = shl_p0[WIDTH];
      end
      OP_SHR: begin
        res_p0 = shr_p0[WIDTH:1];
        cy_p0  = shr_p0[0];
      end
      default: ;
    endcase
  end

`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL = 4'b1001;
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t               state;
  logic [CNT_W-1:0]     mul_cnt;
  logic                 mul_start;
  logic [2*WIDTH-1:0]   mcand_p1;
  logic [WIDTH-1:0]     mplier_p1;
  logic [2*WIDTH-1:0]   acc_p1;

  assign mul_start = accept && (alu_sel == OP_MUL);
  assign in_ready  = (state == S_IDLE) && (!out_valid || out_ready);

  // busy is registered alongside the state so it tracks MUL and DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      mul_cnt <= '0;
      busy    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (mul_start) begin
            state   <= S_MUL;
            mul_cnt <= '0;
            busy    <= 1'b1;
          end
        end
        S_MUL: begin
          mul_cnt <= mul_cnt + CNT_W'(1);
          if (mul_cnt == CNT_W'(WIDTH-1)) state <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // ---- stage p1: shift-add multiplier, LSB of the multiplier first ----
  always_ff @(posedge clk) begin
    if (mul_start) begin
      mcand_p1  <= {{WIDTH{1'b0}}, a};
      mplier_p1 <= b;
      acc_p1    <= '0;
    end else if (state == S_MUL) begin
      if (mplier_p1[0]) acc_p1 <= acc_p1 + mcand_p1;
      mcand_p1  <= mcand_p1 << 1;
      mplier_p1 <= mplier_p1 >> 1;
    end
  end

  assign load   = (accept && !mul_start) || (state == S_DONE);
  assign ld_res = (state == S_DONE) ? acc_p1[WIDTH-1:0] : res_p0;
  assign ld_cy  = (state == S_DONE) ? |acc_p1[2*WIDTH-1:WIDTH] : cy_p0;
  assign ld_ov  = (state == S_DONE) ? 1'b0 : ov_p0;
`else
  assign in_ready = !out_valid || out_ready;
  assign busy     = 1'b0;
  assign load     = accept;
  assign ld_res   = res_p0;
  assign ld_cy    = cy_p0;
  assign ld_ov    = ov_p0;
`endif

  // ---- output register: held until consumed, reloadable on the handshake ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      carry_q   <= 1'b0;
      zero      <= 1'b0;
      negative  <= 1'b0;
      overflow  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      result    <= ld_res;
      carry_q   <= ld_cy;
      zero      <= (ld_res == '0);
      negative  <= ld_res[WIDTH-1];
      overflow  <= ld_ov;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign carry = carry_q;

endmodule
